// File: rtl/fixed_mult_pipe_if.sv
// Operand/result handshake bundle for fixed_mult_pipe.
// The master side supplies operands and accepts results; the slave side is the multiplier.
interface fixed_mult_pipe_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] p_out;
  logic             overflow;
  logic             underflow_q;
  logic             clr_sticky;
  logic             ovf_sticky;
  logic             udf_sticky;

  modport master (
    output in_valid, a_in, b_in, out_ready, clr_sticky,
    input  in_ready, out_valid, p_out, overflow, underflow_q, ovf_sticky, udf_sticky
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready, clr_sticky,
    output in_ready, out_valid, p_out, overflow, underflow_q, ovf_sticky, udf_sticky
  );
endinterface

// File: rtl/fixed_mult_pipe.sv
// Pipelined signed Q(WIDTH-FRACT_BITS).FRACT_BITS multiplier with valid/ready backpressure,
// optional rounding/saturation and sticky range flags. Latency = STAGES; FRACT_BITS must be >= 1.
module fixed_mult_pipe #(
  parameter int WIDTH      = 128,
  parameter int FRACT_BITS = 8,
  parameter int STAGES     = 3,
  parameter int SATURATE   = 1,
  parameter int ROUND      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  fixed_mult_pipe_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int SB = WIDTH - 1 + FRACT_BITS;
  localparam logic [PW-1:0] RND_ADD = (ROUND != 0) ? (PW'(1) << (FRACT_BITS - 1)) : '0;

  logic                  adv;
  logic                  v0_q;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic [PW-1:0]         full;
  logic [PW-1:0]         rnd_full;
  logic [FRACT_BITS-1:0] frac_unused;
  logic                  in_range;
  logic                  ovf;
  logic                  udf;
  logic [WIDTH-1:0]      res;
  logic [WIDTH-1:0]      p_last;
  logic                  v_last;
  logic                  ovf_last;
  logic                  udf_last;
  logic                  ovf_sticky_q;
  logic                  ovf_sticky_d;
  logic                  udf_sticky_q;
  logic                  udf_sticky_d;

  // The whole pipe moves in lockstep; only a held result at the output stalls it.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (adv) begin
      v0_q <= bus.in_valid;
      a_q  <= bus.a_in;
      b_q  <= bus.b_in;
    end
  end

  // Range check: the result sign bit and every bit above it must agree for the value to fit.
  always_comb begin
    full     = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    rnd_full = full + RND_ADD;
    in_range = (&rnd_full[PW-1:SB]) || !(|rnd_full[PW-1:SB]);
    ovf      = !rnd_full[PW-1] && !in_range;
    udf      = rnd_full[PW-1] && !in_range;
    res      = rnd_full[SB:FRACT_BITS];
    if (SATURATE != 0 && ovf) res = {1'b0, {(WIDTH-1){1'b1}}};
    if (SATURATE != 0 && udf) res = {1'b1, {(WIDTH-1){1'b0}}};
  end

  assign frac_unused = rnd_full[FRACT_BITS-1:0];

  generate
    if (STAGES == 1) begin : g_comb_out
      assign p_last   = res;
      assign v_last   = v0_q;
      assign ovf_last = v0_q && ovf;
      assign udf_last = v0_q && udf;
    end else begin : g_reg_out
      for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_stage
        logic [WIDTH-1:0] p_q;
        logic [WIDTH-1:0] p_d;
        logic             v_q, v_d, o_q, o_d, u_q, u_d;

        if (gi == 0) begin : g_head
          assign p_d = res;
          assign v_d = v0_q;
          assign o_d = v0_q && ovf;
          assign u_d = v0_q && udf;
        end else begin : g_tail
          assign p_d = g_stage[gi-1].p_q;
          assign v_d = g_stage[gi-1].v_q;
          assign o_d = g_stage[gi-1].o_q;
          assign u_d = g_stage[gi-1].u_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            p_q <= '0;
            v_q <= 1'b0;
            o_q <= 1'b0;
            u_q <= 1'b0;
          end else if (adv) begin
            p_q <= p_d;
            v_q <= v_d;
            o_q <= o_d;
            u_q <= u_d;
          end
        end
      end
      assign p_last   = g_stage[STAGES-2].p_q;
      assign v_last   = g_stage[STAGES-2].v_q;
      assign ovf_last = g_stage[STAGES-2].o_q;
      assign udf_last = g_stage[STAGES-2].u_q;
    end
  endgenerate

  assign bus.out_valid   = v_last;
  assign bus.p_out       = p_last;
  assign bus.overflow    = ovf_last;
  assign bus.underflow_q = udf_last;

  // A flag delivered on an output handshake beats a simultaneous clear.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    udf_sticky_d = udf_sticky_q;
    if (bus.clr_sticky) begin
      ovf_sticky_d = 1'b0;
      udf_sticky_d = 1'b0;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (ovf_last) ovf_sticky_d = 1'b1;
      if (udf_last) udf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  assign bus.ovf_sticky = ovf_sticky_q;
  assign bus.udf_sticky = udf_sticky_q;
endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Bench for fixed_mult_pipe: three instances (saturate, wrap, round) share one stimulus stream
// and are checked against an integer-arithmetic reference with per-instance scoreboards.
module tb_fixed_mult_pipe;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          check_latency = 1'b0;
  bit          last_in_hs = 1'b0;
  ent_t        sb [3][$];
  bit          exp_os [3];
  bit          exp_us [3];
  bit          prev_stall [3];
  logic [15:0] prev_p [3];

  always #5 clk = ~clk;

  fixed_mult_pipe_if #(.WIDTH(16)) ifc0 ();
  fixed_mult_pipe_if #(.WIDTH(16)) ifc1 ();
  fixed_mult_pipe_if #(.WIDTH(16)) ifc2 ();

  assign ifc0.in_valid = in_valid;  assign ifc1.in_valid = in_valid;  assign ifc2.in_valid = in_valid;
  assign ifc0.a_in = a_in;          assign ifc1.a_in = a_in;          assign ifc2.a_in = a_in;
  assign ifc0.b_in = b_in;          assign ifc1.b_in = b_in;          assign ifc2.b_in = b_in;
  assign ifc0.out_ready = out_ready; assign ifc1.out_ready = out_ready; assign ifc2.out_ready = out_ready;
  assign ifc0.clr_sticky = clr_sticky; assign ifc1.clr_sticky = clr_sticky; assign ifc2.clr_sticky = clr_sticky;

  fixed_mult_pipe #(.WIDTH(16), .FRACT_BITS(8), .STAGES(STAGES), .SATURATE(1), .ROUND(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
  fixed_mult_pipe #(.WIDTH(16), .FRACT_BITS(8), .STAGES(STAGES), .SATURATE(0), .ROUND(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
  fixed_mult_pipe #(.WIDTH(16), .FRACT_BITS(8), .STAGES(STAGES), .SATURATE(1), .ROUND(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact product in Q8.8 arithmetic, floor to the result LSB, then range-check.
  function automatic logic [17:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input bit sat, input bit rnd);
    longint      full, q;
    logic        of, uf;
    logic [15:0] p;
    full = longint'($signed(a)) * longint'($signed(b));
    if (rnd) full += 128;
    q  = full >>> 8;
    of = (q > 32767);
    uf = (q < -32768);
    p  = q[15:0];
    if (sat && of) p = 16'h7FFF;
    if (sat && uf) p = 16'h8000;
    return {of, uf, p};
  endfunction

  task automatic reset_check(input int id, input logic ov, input logic [15:0] p, input logic of,
                             input logic uf, input logic os, input logic us);
    chk($sformatf("d%0d rst_valid", id), 32'(ov), 0);
    chk($sformatf("d%0d rst_p", id), 32'(p), 0);
    chk($sformatf("d%0d rst_flags", id), 32'({of, uf}), 0);
    chk($sformatf("d%0d rst_sticky", id), 32'({os, us}), 0);
    sb[id].delete();
    exp_os[id] = 1'b0;
    exp_us[id] = 1'b0;
    prev_stall[id] = 1'b0;
  endtask

  task automatic check_dut(input int id, input bit sat, input bit rnd, input logic ov,
                           input logic ir, input logic [15:0] p, input logic of, input logic uf,
                           input logic os, input logic us);
    logic [17:0] r;
    ent_t        e;
    int          depth;
    bit          nos, nus;
    depth = sb[id].size();
    chk($sformatf("d%0d in_ready", id), 32'(ir), 32'(!ov || out_ready));
    if (depth == 0) chk($sformatf("d%0d idle_valid", id), 32'(ov), 0);
    if (depth == STAGES && !out_ready) chk($sformatf("d%0d full_stall", id), 32'(ir), 0);
    if (!ov) chk($sformatf("d%0d idle_flags", id), 32'({of, uf}), 0);
    if (prev_stall[id]) begin
      chk($sformatf("d%0d hold_valid", id), 32'(ov), 1);
      chk($sformatf("d%0d hold_p", id), 32'(p), 32'(prev_p[id]));
    end
    chk($sformatf("d%0d ovf_sticky", id), 32'(os), 32'(exp_os[id]));
    chk($sformatf("d%0d udf_sticky", id), 32'(us), 32'(exp_us[id]));
    nos = clr_sticky ? 1'b0 : exp_os[id];
    nus = clr_sticky ? 1'b0 : exp_us[id];
    if (ov && out_ready && depth > 0) begin
      e = sb[id].pop_front();
      r = ref_mul(e.a, e.b, sat, rnd);
      chk($sformatf("d%0d p_out a=%h b=%h", id, e.a, e.b), 32'(p), 32'(r[15:0]));
      chk($sformatf("d%0d overflow", id), 32'(of), 32'(r[17]));
      chk($sformatf("d%0d underflow", id), 32'(uf), 32'(r[16]));
      if (check_latency) chk($sformatf("d%0d latency", id), 32'(cyc - e.cyc), STAGES);
      if (r[17]) nos = 1'b1;
      if (r[16]) nus = 1'b1;
    end
    exp_os[id] = nos;
    exp_us[id] = nus;
    prev_stall[id] = ov && !out_ready;
    prev_p[id] = p;
    if (in_valid && ir) begin
      e.a = a_in;
      e.b = b_in;
      e.cyc = cyc;
      sb[id].push_back(e);
    end
  endtask

  // Sample and score at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      reset_check(0, ifc0.out_valid, ifc0.p_out, ifc0.overflow, ifc0.underflow_q, ifc0.ovf_sticky, ifc0.udf_sticky);
      reset_check(1, ifc1.out_valid, ifc1.p_out, ifc1.overflow, ifc1.underflow_q, ifc1.ovf_sticky, ifc1.udf_sticky);
      reset_check(2, ifc2.out_valid, ifc2.p_out, ifc2.overflow, ifc2.underflow_q, ifc2.ovf_sticky, ifc2.udf_sticky);
      last_in_hs = 1'b0;
    end else begin
      check_dut(0, 1'b1, 1'b0, ifc0.out_valid, ifc0.in_ready, ifc0.p_out, ifc0.overflow,
                ifc0.underflow_q, ifc0.ovf_sticky, ifc0.udf_sticky);
      check_dut(1, 1'b0, 1'b0, ifc1.out_valid, ifc1.in_ready, ifc1.p_out, ifc1.overflow,
                ifc1.underflow_q, ifc1.ovf_sticky, ifc1.udf_sticky);
      check_dut(2, 1'b1, 1'b1, ifc2.out_valid, ifc2.in_ready, ifc2.p_out, ifc2.overflow,
                ifc2.underflow_q, ifc2.ovf_sticky, ifc2.udf_sticky);
      last_in_hs = in_valid && ifc0.in_ready;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_in_hs) break;
    end
    chk("send_handshake", 32'(last_in_hs), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (sb[0].size() + sb[1].size() + sb[2].size()) > 0; i++) tick();
    chk("drain_empty", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 0);
  endtask

  initial begin
    int k;
    int t;

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed arithmetic vectors, no stalls, exact latency
    out_ready = 1'b1;
    check_latency = 1'b1;
    send(16'h0180, 16'h0200);
    send(16'hFE80, 16'h0200);
    send(16'h7F00, 16'h0200);
    send(16'h8000, 16'h0200);
    send(16'h8000, 16'h0100);
    send(16'h0001, 16'h0080);
    send(16'h4000, 16'h0200);
    drain();
    tick();

    // Sticky clear alone, then clear colliding with an overflow handshake, then clear alone
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    tick();
    send(16'h7F00, 16'h0200);
    for (int i = 0; i < 10 && !ifc0.out_valid; i++) tick();
    chk("ovf_result_seen", 32'(ifc0.out_valid), 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    tick();
    check_latency = 1'b0;

    // Backpressure: six back-to-back pairs with the sink stalled for cycles 2..8
    k = 1;
    for (int c = 0; c < 24; c++) begin
      out_ready = !(c >= 2 && c <= 8);
      in_valid = (k <= 6);
      a_in = 16'(k);
      b_in = 16'h0100;
      tick();
      if (last_in_hs) k++;
    end
    chk("bp_all_sent", 32'(k), 7);
    drain();

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        a_in = 16'($urandom);
        b_in = 16'($urandom);
      end else begin
        t = $urandom_range(0, 4095);
        a_in = 16'(t - 2048);
        t = $urandom_range(0, 4095);
        b_in = 16'(t - 2048);
      end
      tick();
    end
    clr_sticky = 1'b0;
    drain();

    // Reset with three transactions in flight and both sticky flags set
    send(16'h7F00, 16'h0200);
    send(16'h8000, 16'h0200);
    drain();
    out_ready = 1'b0;
    send(16'h0100, 16'h0100);
    send(16'h0200, 16'h0100);
    send(16'h0300, 16'h0100);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
